// File: rtl/dram_cmd_if.sv
// rtl/dram_cmd_if.sv - command handshake bundle between DRAM controller and responder
interface dram_cmd_if #(
    parameter int NUMBER_OF_BANKS = 8,
    parameter int NUMBER_OF_ROWS  = 128,
    parameter int NUMBER_OF_COLS  = 8
);
    localparam int BW = $clog2(NUMBER_OF_BANKS);
    localparam int RW = $clog2(NUMBER_OF_ROWS);
    localparam int CW = $clog2(NUMBER_OF_COLS);

    logic                       cmd_req;
    logic [1:0]                 cmd;
    logic [BW-1:0]              bank_id;
    logic [RW-1:0]              row_id;
    logic [CW-1:0]              col_id;
    logic                       cmd_ack;
    logic                       busy;
    logic [NUMBER_OF_BANKS-1:0] bank_open;
    logic                       rd_valid;
    logic [CW-1:0]              rd_col;
    logic                       err_valid;
    logic [1:0]                 err_code;
    logic                       refresh_req;

    modport master (
        output cmd_req, cmd, bank_id, row_id, col_id,
        input  cmd_ack, busy, bank_open, rd_valid, rd_col, err_valid, err_code, refresh_req
    );

    modport slave (
        input  cmd_req, cmd, bank_id, row_id, col_id,
        output cmd_ack, busy, bank_open, rd_valid, rd_col, err_valid, err_code, refresh_req
    );
endinterface

// File: rtl/dram_cmd_responder.sv
// rtl/dram_cmd_responder.sv - DRAM command target with bank state and fixed timing latencies
// Optional periodic refresh request generator enabled by REFRESH_TIMER_EN.
module dram_cmd_responder #(
    parameter int NUMBER_OF_BANKS = 8,
    parameter int NUMBER_OF_ROWS  = 128,
    parameter int NUMBER_OF_COLS  = 8,
    parameter int T_RCD           = 3,
    parameter int T_CL            = 2,
    parameter int T_RP            = 3,
    parameter int T_RFC           = 8,
    parameter int T_REFI          = 512
) (
    input logic       clk,
    input logic       rst_b,
    dram_cmd_if.slave bus
);
    localparam int NB    = NUMBER_OF_BANKS;
    localparam int BW    = $clog2(NUMBER_OF_BANKS);
    localparam int RW    = $clog2(NUMBER_OF_ROWS);
    localparam int CW    = $clog2(NUMBER_OF_COLS);
    localparam int T_M1  = (T_RCD > T_CL) ? T_RCD : T_CL;
    localparam int T_M2  = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int CNTW  = $clog2(T_MAX + 1);

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_REF = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [1:0]      cmd_q;
    logic [BW-1:0]   bank_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic [NB-1:0]   bank_open_q, open_d;
    logic [RW-1:0]   open_row [NB];
    logic            ack_q, busy_q, rd_valid_q, err_valid_q;
    logic [CW-1:0]   rd_col_q;
    logic [1:0]      err_code_q;
    logic            accept, done, row_wr, rdv_d, errv_d;
    logic [1:0]      code_d;

    assign accept = (state_q == IDLE) && bus.cmd_req;
    assign done   = (state_q == BUSY) && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.cmd_req) begin
                state_d = BUSY;
                case (bus.cmd)
                    CMD_ACT: cnt_d = CNTW'(T_RCD - 1);
                    CMD_RD:  cnt_d = CNTW'(T_CL - 1);
                    CMD_REF: cnt_d = CNTW'(T_RFC - 1);
                    default: cnt_d = CNTW'(T_RP - 1);
                endcase
            end
            BUSY: if (cnt_q == '0) state_d = ACK;
                  else             cnt_d   = cnt_q - 1'b1;
            ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outcome of the latched command, evaluated against bank state frozen since accept.
    always_comb begin
        open_d = bank_open_q;
        row_wr = 1'b0;
        rdv_d  = 1'b0;
        errv_d = 1'b0;
        code_d = 2'b00;
        case (cmd_q)
            CMD_ACT: if (bank_open_q[bank_q]) begin
                errv_d = 1'b1;
                code_d = 2'b01;
            end else begin
                open_d[bank_q] = 1'b1;
                row_wr         = 1'b1;
            end
            CMD_RD: if (bank_open_q[bank_q] && open_row[bank_q] == row_q) begin
                rdv_d = 1'b1;
            end else begin
                errv_d = 1'b1;
                code_d = 2'b10;
            end
            CMD_REF: begin
                if (|bank_open_q) begin
                    errv_d = 1'b1;
                    code_d = 2'b11;
                end
                open_d = '0;
            end
            default: open_d[bank_q] = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            cmd_q       <= '0;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            bank_open_q <= '0;
            for (int i = 0; i < NB; i++) open_row[i] <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_col_q    <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            if (accept) begin
                cmd_q  <= bus.cmd;
                bank_q <= bus.bank_id;
                row_q  <= bus.row_id;
                col_q  <= bus.col_id;
                busy_q <= 1'b1;
            end
            ack_q       <= done;
            rd_valid_q  <= done && rdv_d;
            rd_col_q    <= (done && rdv_d) ? col_q : '0;
            err_valid_q <= done && errv_d;
            err_code_q  <= (done && errv_d) ? code_d : 2'b00;
            if (done) begin
                busy_q      <= 1'b0;
                bank_open_q <= open_d;
                if (row_wr) open_row[bank_q] <= row_q;
            end
        end
    end

    assign bus.cmd_ack   = ack_q;
    assign bus.busy      = busy_q;
    assign bus.bank_open = bank_open_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_col    = rd_col_q;
    assign bus.err_valid = err_valid_q;
    assign bus.err_code  = err_code_q;

`ifdef REFRESH_TIMER_EN
    logic [15:0] refi_cnt_q;
    logic        refresh_req_q;

    // Counter holds while a refresh is pending; only an acked REFRESH restarts it.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            refi_cnt_q    <= '0;
            refresh_req_q <= 1'b0;
        end else if (done && cmd_q == CMD_REF) begin
            refi_cnt_q    <= '0;
            refresh_req_q <= 1'b0;
        end else if (!refresh_req_q) begin
            refi_cnt_q <= refi_cnt_q + 16'd1;
            if (refi_cnt_q + 16'd1 == 16'(T_REFI - 1)) refresh_req_q <= 1'b1;
        end
    end

    assign bus.refresh_req = refresh_req_q;
`else
    assign bus.refresh_req = 1'b0;
`endif
endmodule

// File: tb/tb_dram_cmd_responder.sv
// tb/tb_dram_cmd_responder.sv - scoreboard bench for dram_cmd_responder
module tb_dram_cmd_responder;
    localparam logic [1:0] ACT = 2'b00, RD = 2'b01, REF = 2'b10, PRE = 2'b11;

    typedef struct {
        int         lat;
        logic       rdv;
        logic [2:0] col;
        logic       errv;
        logic [1:0] code;
        logic [7:0] open;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    dram_cmd_if #(.NUMBER_OF_BANKS(8), .NUMBER_OF_ROWS(128), .NUMBER_OF_COLS(8)) bus ();

    dram_cmd_responder #(
        .NUMBER_OF_BANKS(8), .NUMBER_OF_ROWS(128), .NUMBER_OF_COLS(8),
        .T_RCD(3), .T_CL(2), .T_RP(3), .T_RFC(8), .T_REFI(16)
    ) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus)
    );

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [7:0] m_open;
    logic [6:0] m_row [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic predict(input logic [1:0] c, input int b, input int r, input int col,
                           output exp_t e);
        e.rdv  = 1'b0;
        e.col  = 3'(col);
        e.errv = 1'b0;
        e.code = 2'b00;
        case (c)
            ACT: begin
                e.lat = 3;
                if (m_open[b]) begin e.errv = 1'b1; e.code = 2'b01; end
                else begin m_open[b] = 1'b1; m_row[b] = 7'(r); end
            end
            RD: begin
                e.lat = 2;
                if (m_open[b] && m_row[b] == 7'(r)) e.rdv = 1'b1;
                else begin e.errv = 1'b1; e.code = 2'b10; end
            end
            REF: begin
                e.lat = 8;
                if (m_open != 8'h00) begin e.errv = 1'b1; e.code = 2'b11; end
                m_open = 8'h00;
            end
            default: begin
                e.lat = 3;
                m_open[b] = 1'b0;
            end
        endcase
        e.open = m_open;
    endtask

    task automatic issue(input logic [1:0] c, input int b, input int r, input int col);
        exp_t e;
        int   n;
        logic got;
        predict(c, b, r, col, e);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        chk("ack_one_cycle", bus.cmd_ack, 1'b0);
        bus.cmd_req = 1'b1;
        bus.cmd     = c;
        bus.bank_id = 3'(b);
        bus.row_id  = 7'(r);
        bus.col_id  = 3'(col);
        @(posedge clk);
        #1;
        chk("busy_at_accept", bus.busy, 1'b1);
        chk("no_pulse_at_accept", {bus.cmd_ack, bus.rd_valid, bus.err_valid}, 3'b000);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.cmd_ack) got = 1'b1;
        end
        bus.cmd_req = 1'b0;
        e = exp_q.pop_front();
        chk("latency", n, e.lat);
        chk("busy_at_ack", bus.busy, 1'b0);
        chk("rd_valid", bus.rd_valid, e.rdv);
        if (e.rdv) chk("rd_col", bus.rd_col, e.col);
        chk("err_valid", bus.err_valid, e.errv);
        if (e.errv) chk("err_code", bus.err_code, e.code);
        chk("bank_open", bus.bank_open, e.open);
    endtask

    initial begin
        int n;
        rst_b       = 1'b1;
        bus.cmd_req = 1'b0;
        bus.cmd     = 2'b00;
        bus.bank_id = '0;
        bus.row_id  = '0;
        bus.col_id  = '0;
        m_open      = 8'h00;
        for (int i = 0; i < 8; i++) m_row[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {bus.cmd_ack, bus.busy, bus.rd_valid, bus.err_valid, bus.refresh_req}, 5'b0);
        chk("rst_bank_open", bus.bank_open, 8'h00);
        @(negedge clk);
        rst_b = 1'b0;

        issue(ACT, 2, 5, 0);
        issue(RD, 2, 5, 6);
        issue(RD, 2, 7, 1);
        issue(ACT, 2, 9, 0);
        issue(RD, 2, 5, 3);
        issue(REF, 0, 0, 0);
        issue(PRE, 3, 0, 0);
        issue(ACT, 0, 1, 0);
        issue(ACT, 7, 127, 0);
        issue(RD, 7, 127, 7);
        issue(RD, 0, 1, 0);
        issue(PRE, 0, 0, 0);
        issue(RD, 0, 1, 2);
        issue(REF, 0, 0, 0);
        issue(REF, 0, 0, 0);
        issue(PRE, 7, 0, 0);
        issue(ACT, 5, 64, 0);

        // Reset lands while an ACTIVATE is counting down.
        @(posedge clk);
        @(negedge clk);
        bus.cmd_req = 1'b1;
        bus.cmd     = ACT;
        bus.bank_id = 3'd1;
        bus.row_id  = 7'd3;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_b = 1'b1;
        #1;
        bus.cmd_req = 1'b0;
        chk("rst_mid_busy", bus.busy, 1'b0);
        chk("rst_mid_bank_open", bus.bank_open, 8'h00);
        m_open = 8'h00;
        @(negedge clk);
        rst_b = 1'b0;
        n = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.cmd_ack) n++;
        end
        chk("rst_mid_no_ack", n, 0);

`ifdef REFRESH_TIMER_EN
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        n = 0;
        while (!bus.refresh_req && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("refi_first_rise", n, 15);
        m_open = 8'h00;
        issue(ACT, 4, 3, 0);
        chk("refi_held", bus.refresh_req, 1'b1);
        issue(REF, 0, 0, 0);
        chk("refi_cleared", bus.refresh_req, 1'b0);
        n = 0;
        while (!bus.refresh_req && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("refi_second_rise", n, 15);
`else
        chk("refresh_tied_low", bus.refresh_req, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
